// File: rtl/deadzone_mc.sv
// deadzone_mc: multi-channel complementary dead-time generator.
// Each channel turns one ocref into P/N outputs with separate rising-edge
// (r_dtr) and falling-edge (r_dtf) dead times and per-output polarity.
// Optional break override is compiled in when DEADZONE_MC_BRK_EN is defined;
// otherwise brk, r_oisp and r_oisn are accepted but have no effect.
module deadzone_mc #(
   parameter int CH_NUM = 4,
   parameter int DT_W   = 10
) (
   input  logic              pe_gen_clk,
   input  logic              pe_gen_rstn,
   input  logic [CH_NUM-1:0] r_dze,
   input  logic [CH_NUM-1:0] r_ccp,
   input  logic [CH_NUM-1:0] r_ccnp,
   input  logic [DT_W-1:0]   r_dtr,
   input  logic [DT_W-1:0]   r_dtf,
   input  logic [CH_NUM-1:0] r_oisp,
   input  logic [CH_NUM-1:0] r_oisn,
   input  logic              brk,
   input  logic [CH_NUM-1:0] ocref,
   output logic [CH_NUM-1:0] chp_out,
   output logic [CH_NUM-1:0] chn_out,
   output logic [CH_NUM-1:0] dt_busy
);

   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_DT_RISE = 2'd1,
      ST_HIGH    = 2'd2,
      ST_DT_FALL = 2'd3
   } state_t;

   localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

`ifndef DEADZONE_MC_BRK_EN
   // Break inputs are intentionally unused in this build.
   logic brk_unused;
   assign brk_unused = &{1'b0, brk, r_oisp, r_oisn};
`endif

   genvar gi;
   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
         state_t          state_reg, state_next;
         logic [DT_W-1:0] cnt_reg, cnt_next;
         logic            ocref_q_reg;
         logic            chp_reg, chn_reg;
         logic            chp_next, chn_next;
         logic            rise, fall;

         assign rise = ocref[gi] & ~ocref_q_reg;
         assign fall = ~ocref[gi] & ocref_q_reg;

         // Next-state, counter and output-level decode for this channel.
         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            if (!r_dze[gi]) begin
               // Dead zone off: plain complementary tracking of ocref.
               state_next = ocref[gi] ? ST_HIGH : ST_LOW;
               cnt_next   = '0;
            end else begin
               case (state_reg)
                  ST_LOW: begin
                     if (rise) begin
                        if (r_dtr == '0) begin
                           state_next = ST_HIGH;
                        end else begin
                           state_next = ST_DT_RISE;
                           cnt_next   = r_dtr;
                        end
                     end
                  end
                  ST_HIGH: begin
                     if (fall) begin
                        if (r_dtf == '0) begin
                           state_next = ST_LOW;
                        end else begin
                           state_next = ST_DT_FALL;
                           cnt_next   = r_dtf;
                        end
                     end
                  end
                  ST_DT_RISE: begin
                     // A fall here aborts the pulse before P is ever driven.
                     if (fall) begin
                        if (r_dtf == '0) begin
                           state_next = ST_LOW;
                           cnt_next   = '0;
                        end else begin
                           state_next = ST_DT_FALL;
                           cnt_next   = r_dtf;
                        end
                     end else if (cnt_reg <= CNT_ONE) begin
                        state_next = ST_HIGH;
                        cnt_next   = '0;
                     end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                     end
                  end
                  default: begin // ST_DT_FALL
                     if (rise) begin
                        if (r_dtr == '0) begin
                           state_next = ST_HIGH;
                           cnt_next   = '0;
                        end else begin
                           state_next = ST_DT_RISE;
                           cnt_next   = r_dtr;
                        end
                     end else if (cnt_reg <= CNT_ONE) begin
                        state_next = ST_LOW;
                        cnt_next   = '0;
                     end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                     end
                  end
               endcase
            end

            chp_next = (state_next == ST_HIGH) ^ r_ccp[gi];
            chn_next = (state_next == ST_LOW) ^ r_ccnp[gi];

`ifdef DEADZONE_MC_BRK_EN
            // Break wins over everything: pins go idle, FSM just follows ocref
            // so release resumes without any dead-time insertion.
            if (brk) begin
               state_next = ocref[gi] ? ST_HIGH : ST_LOW;
               cnt_next   = '0;
               chp_next   = r_oisp[gi];
               chn_next   = r_oisn[gi];
            end
`endif
         end

         // Channel state, counter, edge history and output registers.
         always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
            if (!pe_gen_rstn) begin
               state_reg   <= ST_LOW;
               cnt_reg     <= '0;
               ocref_q_reg <= 1'b0;
               chp_reg     <= 1'b0;
               chn_reg     <= 1'b0;
            end else begin
               state_reg   <= state_next;
               cnt_reg     <= cnt_next;
               ocref_q_reg <= ocref[gi];
               chp_reg     <= chp_next;
               chn_reg     <= chn_next;
            end
         end

         assign chp_out[gi] = chp_reg;
         assign chn_out[gi] = chn_reg;
         assign dt_busy[gi] = (state_reg == ST_DT_RISE) || (state_reg == ST_DT_FALL);
      end
   endgenerate

endmodule

// File: tb/tb_deadzone_mc.sv
// Testbench for deadzone_mc: per-scenario tasks push the expected per-cycle
// channel outputs into a scoreboard queue and pop/compare after each edge.
module tb_deadzone_mc;

   localparam int CH_NUM = 4;
   localparam int DT_W   = 10;

   logic              clk;
   logic              rstn;
   logic [CH_NUM-1:0] r_dze, r_ccp, r_ccnp, r_oisp, r_oisn, ocref;
   logic [DT_W-1:0]   r_dtr, r_dtf;
   logic              brk;
   logic [CH_NUM-1:0] chp_out, chn_out, dt_busy;

   typedef struct packed {
      logic p;
      logic n;
      logic b;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   deadzone_mc #(.CH_NUM(CH_NUM), .DT_W(DT_W)) dut (
      .pe_gen_clk (clk),
      .pe_gen_rstn(rstn),
      .r_dze      (r_dze),
      .r_ccp      (r_ccp),
      .r_ccnp     (r_ccnp),
      .r_dtr      (r_dtr),
      .r_dtf      (r_dtf),
      .r_oisp     (r_oisp),
      .r_oisn     (r_oisn),
      .brk        (brk),
      .ocref      (ocref),
      .chp_out    (chp_out),
      .chn_out    (chn_out),
      .dt_busy    (dt_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      ocref = '0;
      brk   = 1'b0;
      for (int i = 0; i < 12; i++) step();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      checks++;
      if ({chp_out, chn_out, dt_busy} !== 12'h000) begin
         failures++;
         $display("FAIL reset_hold got %h required 000", {chp_out, chn_out, dt_busy});
      end
      @(posedge clk);
      #2 rstn = 1'b1;
      step();
      checks++;
      if ({chp_out, chn_out, dt_busy} !== {4'h0, 4'hF, 4'h0}) begin
         failures++;
         $display("FAIL reset_release got %h required 0f0", {chp_out, chn_out, dt_busy});
      end
      $display("test_reset done");
   endtask

   task automatic test_rise();
      exp_t e;
      r_dtr = 10'd5;
      r_dtf = 10'd5;
      ocref[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         sb_q.push_back('{p: (k >= 5), n: 1'b0, b: (k < 5)});
         step();
         e = sb_q.pop_front();
         checks++;
         if ({chp_out[0], chn_out[0], dt_busy[0]} !== e) begin
            failures++;
            $display("FAIL rise k=%0d got p/n/b=%b required %b", k,
                     {chp_out[0], chn_out[0], dt_busy[0]}, e);
         end
      end
      settle();
      $display("test_rise done");
   endtask

   task automatic test_asym();
      exp_t e;
      r_dtr = 10'd3;
      r_dtf = 10'd7;
      r_ccnp[1] = 1'b1;
      step();
      for (int k = 0; k < 35; k++) begin
         ocref[1] = (k < 20);
         sb_q.push_back('{p: (k >= 3 && k < 20), n: ~(k >= 27),
                          b: (k < 3) || (k >= 20 && k < 27)});
         step();
         e = sb_q.pop_front();
         checks++;
         if ({chp_out[1], chn_out[1], dt_busy[1]} !== e) begin
            failures++;
            $display("FAIL asym k=%0d got p/n/b=%b required %b", k,
                     {chp_out[1], chn_out[1], dt_busy[1]}, e);
         end
      end
      r_ccnp[1] = 1'b0;
      settle();
      $display("test_asym done");
   endtask

   task automatic test_short();
      exp_t e;
      r_dtr = 10'd8;
      r_dtf = 10'd2;
      for (int k = 0; k < 10; k++) begin
         ocref[2] = (k < 4);
         sb_q.push_back('{p: 1'b0, n: (k >= 6), b: (k < 6)});
         step();
         e = sb_q.pop_front();
         checks++;
         if ({chp_out[2], chn_out[2], dt_busy[2]} !== e) begin
            failures++;
            $display("FAIL short k=%0d got p/n/b=%b required %b", k,
                     {chp_out[2], chn_out[2], dt_busy[2]}, e);
         end
      end
      settle();
      $display("test_short done");
   endtask

   task automatic test_zero_dt();
      exp_t e;
      logic bitv;
      for (int phase = 0; phase < 2; phase++) begin
         if (phase == 0) begin
            r_dtr = 10'd0;
            r_dtf = 10'd0;
         end else begin
            r_dtr    = 10'd5;
            r_dtf    = 10'd5;
            r_dze[3] = 1'b0;
         end
         for (int k = 0; k < 16; k++) begin
            bitv = 1'($urandom_range(0, 1));
            ocref[3] = bitv;
            sb_q.push_back('{p: bitv, n: ~bitv, b: 1'b0});
            step();
            e = sb_q.pop_front();
            checks++;
            if ({chp_out[3], chn_out[3], dt_busy[3]} !== e) begin
               failures++;
               $display("FAIL zero_dt phase=%0d k=%0d got p/n/b=%b required %b", phase, k,
                        {chp_out[3], chn_out[3], dt_busy[3]}, e);
            end
         end
      end
      r_dze[3] = 1'b1;
      settle();
      $display("test_zero_dt done");
   endtask

   task automatic test_brk();
      exp_t e;
      r_dtr  = 10'd6;
      r_dtf  = 10'd0;
      r_oisp = 4'b0001;
      r_oisn = 4'b0000;
      for (int k = 0; k < 9; k++) begin
         ocref[0] = 1'b1;
         brk      = (k == 2);
`ifdef DEADZONE_MC_BRK_EN
         if (k < 2) sb_q.push_back('{p: 1'b0, n: 1'b0, b: 1'b1});
         else       sb_q.push_back('{p: 1'b1, n: 1'b0, b: 1'b0});
`else
         sb_q.push_back('{p: (k >= 6), n: 1'b0, b: (k < 6)});
`endif
         step();
         e = sb_q.pop_front();
         checks++;
         if ({chp_out[0], chn_out[0], dt_busy[0]} !== e) begin
            failures++;
            $display("FAIL brk k=%0d got p/n/b=%b required %b", k,
                     {chp_out[0], chn_out[0], dt_busy[0]}, e);
         end
      end
      r_oisp = '0;
      settle();
      $display("test_brk done");
   endtask

   task automatic test_reset_mid();
      r_dtr = 10'd0;
      r_dtf = 10'd7;
      ocref[1] = 1'b1;
      step();
      step();
      ocref[1] = 1'b0;
      step();
      step();
      checks++;
      if (dt_busy[1] !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_pre busy got %b required 1", dt_busy[1]);
      end
      #3 rstn = 1'b0;
      #1;
      checks++;
      if ({chp_out, chn_out, dt_busy} !== 12'h000) begin
         failures++;
         $display("FAIL reset_mid_async got %h required 000", {chp_out, chn_out, dt_busy});
      end
      @(posedge clk);
      #2 rstn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         checks++;
         if ({chp_out[1], chn_out[1], dt_busy[1]} !== 3'b010) begin
            failures++;
            $display("FAIL reset_mid_after k=%0d got p/n/b=%b required 010", k,
                     {chp_out[1], chn_out[1], dt_busy[1]});
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      rstn   = 1'b0;
      r_dze  = 4'hF;
      r_ccp  = '0;
      r_ccnp = '0;
      r_oisp = '0;
      r_oisn = '0;
      r_dtr  = '0;
      r_dtf  = '0;
      brk    = 1'b0;
      ocref  = '0;
      test_reset();
      test_rise();
      test_asym();
      test_short();
      test_zero_dt();
      test_brk();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
